axi_lite_mem_slv: RTL and testbench

//  AXI4-Lite memory slave that sits on one master port of axi_lite_xbar and terminates its traffic.

---
 rtl/axi_lite_mem_slv.sv | 133 +++++++++++++
 tb/tb_axi_lite_mem_slv.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mem_slv.sv
// axi_lite_mem_slv: AXI4-Lite flop-array memory slave with byte strobes and SLVERR outside its window.
package axi_lite_mem_slv_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } ax_t;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
    } w_t;
    typedef struct packed {
        logic [1:0] resp;
    } b_t;
    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
    } r_t;
    typedef struct packed {
        ax_t  aw;
        logic aw_valid;
        w_t   w;
        logic w_valid;
        logic b_ready;
        ax_t  ar;
        logic ar_valid;
        logic r_ready;
    } req_t;
    typedef struct packed {
        logic aw_ready;
        logic w_ready;
        b_t   b;
        logic b_valid;
        logic ar_ready;
        r_t   r;
        logic r_valid;
    } resp_t;
endpackage

module axi_lite_mem_slv #(
    parameter int unsigned             AxiAddrWidth = 32,
    parameter int unsigned             AxiDataWidth = 64,
    parameter int unsigned             NumWords     = 64,
    parameter logic [AxiAddrWidth-1:0] BaseAddr     = '0,
    parameter type                     req_t        = axi_lite_mem_slv_pkg::req_t,
    parameter type                     resp_t       = axi_lite_mem_slv_pkg::resp_t
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  req_t  slv_req_i,
    output resp_t slv_resp_o
);
    localparam int unsigned             StrbWidth = AxiDataWidth / 8;
    localparam int unsigned             OffW      = $clog2(StrbWidth);
    localparam int unsigned             IdxW      = NumWords > 1 ? $clog2(NumWords) : 1;
    localparam logic [AxiAddrWidth-1:0] Depth     = AxiAddrWidth'(NumWords);
    localparam logic [AxiAddrWidth-1:0] Span      = AxiAddrWidth'(NumWords * StrbWidth);

    logic [AxiDataWidth-1:0] mem_q [NumWords];
    logic                    b_valid_q, b_valid_d, r_valid_q, r_valid_d;
    logic [1:0]              b_resp_q, b_resp_d, r_resp_q, r_resp_d;
    logic [AxiDataWidth-1:0] r_data_q, r_data_d;
    logic [AxiAddrWidth-1:0] aw_off, ar_off;
    logic [IdxW-1:0]         aw_idx, ar_idx;
    logic                    aw_in, ar_in, aw_hs, ar_rdy, ar_hs;
    logic                    unused;

    // Offsets wrap, so the explicit >= BaseAddr test rejects addresses below the window.
    assign aw_off = slv_req_i.aw.addr - BaseAddr;
    assign ar_off = slv_req_i.ar.addr - BaseAddr;
    assign aw_in  = slv_req_i.aw.addr >= BaseAddr && (aw_off >> OffW) < Depth;
    assign ar_in  = slv_req_i.ar.addr >= BaseAddr && (ar_off >> OffW) < Depth;
    assign aw_idx = aw_off[OffW +: IdxW];
    assign ar_idx = ar_off[OffW +: IdxW];
    assign unused = ^{slv_req_i.aw.prot, slv_req_i.ar.prot, aw_off, ar_off};

    // A lone AW or W is never taken; both channels handshake together.
    assign aw_hs  = slv_req_i.aw_valid & slv_req_i.w_valid & (~b_valid_q | slv_req_i.b_ready);
    assign ar_rdy = ~r_valid_q | slv_req_i.r_ready;
    assign ar_hs  = slv_req_i.ar_valid & ar_rdy;

    always_comb begin
        b_valid_d = aw_hs | (b_valid_q & ~slv_req_i.b_ready);
        b_resp_d  = aw_hs ? (aw_in ? 2'b00 : 2'b10) : b_resp_q;
        r_valid_d = ar_hs | (r_valid_q & ~slv_req_i.r_ready);
        r_resp_d  = ar_hs ? (ar_in ? 2'b00 : 2'b10) : r_resp_q;
        r_data_d  = ar_hs ? (ar_in ? mem_q[ar_idx] : '0) : r_data_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_valid_q <= 1'b0;
            b_resp_q  <= 2'b00;
            r_valid_q <= 1'b0;
            r_resp_q  <= 2'b00;
            r_data_q  <= '0;
        end else begin
            b_valid_q <= b_valid_d;
            b_resp_q  <= b_resp_d;
            r_valid_q <= r_valid_d;
            r_resp_q  <= r_resp_d;
            r_data_q  <= r_data_d;
        end
    end

    // Reads sample mem_q in the same cycle a write lands, so a colliding read sees the old word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumWords; i++) mem_q[i] <= '0;
        end else if (aw_hs && aw_in) begin
            for (int unsigned k = 0; k < StrbWidth; k++)
                if (slv_req_i.w.strb[k]) mem_q[aw_idx][8*k +: 8] <= slv_req_i.w.data[8*k +: 8];
        end
    end

    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = aw_hs;
        slv_resp_o.w_ready  = aw_hs;
        slv_resp_o.b.resp   = b_resp_q;
        slv_resp_o.b_valid  = b_valid_q;
        slv_resp_o.ar_ready = ar_rdy;
        slv_resp_o.r.data   = r_data_q;
        slv_resp_o.r.resp   = r_resp_q;
        slv_resp_o.r_valid  = r_valid_q;
    end

    a_align: assert property (@(posedge clk_i) (BaseAddr % Span) == '0);
    a_width: assert property (@(posedge clk_i) AxiDataWidth == 32 || AxiDataWidth == 64);
    a_b_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        b_valid_q && !slv_req_i.b_ready |=> b_valid_q && $stable(b_resp_q));
    a_r_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_valid_q && !slv_req_i.r_ready |=> r_valid_q && $stable(r_data_q) && $stable(r_resp_q));
endmodule

// File: tb/tb_axi_lite_mem_slv.sv
// tb_axi_lite_mem_slv: vector table, corner-case sequences and randomized traffic against a word-array model.
module tb_axi_lite_mem_slv;
    localparam logic [31:0] BASE = 32'h2000;
    localparam int          NW   = 64;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  exp_resp;
        logic [63:0] exp_data;
    } vec_t;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    axi_lite_mem_slv_pkg::req_t  req;
    axi_lite_mem_slv_pkg::resp_t resp;
    logic [63:0]                 model [NW];
    int                          checks = 0;
    int                          failures = 0;
    vec_t                        tbl [13];

    axi_lite_mem_slv #(
        .AxiAddrWidth(32),
        .AxiDataWidth(64),
        .NumWords(NW),
        .BaseAddr(BASE),
        .req_t(axi_lite_mem_slv_pkg::req_t),
        .resp_t(axi_lite_mem_slv_pkg::resp_t)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .slv_req_i(req),
        .slv_resp_o(resp)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_in(input logic [31:0] a);
        return a >= BASE && (a - BASE) / 8 < NW;
    endfunction

    function automatic logic [1:0] m_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        int idx;
        if (!m_in(a)) return 2'b10;
        idx = int'((a - BASE) / 8);
        for (int k = 0; k < 8; k++)
            if (s[k]) model[idx][8*k +: 8] = d[8*k +: 8];
        return 2'b00;
    endfunction

    function automatic logic [63:0] m_read(input logic [31:0] a);
        return m_in(a) ? model[int'((a - BASE) / 8)] : 64'h0;
    endfunction

    function automatic logic [1:0] m_resp(input logic [31:0] a);
        return m_in(a) ? 2'b00 : 2'b10;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NW; i++) model[i] = '0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            input int stall, output logic [1:0] rsp);
        int n = 0;
        @(negedge clk);
        req.aw.addr = a;
        req.aw.prot = 3'($urandom);
        req.w.data = d;
        req.w.strb = s;
        req.aw_valid = 1'b1;
        req.w_valid = 1'b1;
        req.b_ready = 1'b0;
        #1;
        while (!resp.aw_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("aw_w_ready", {63'd0, resp.aw_ready & resp.w_ready}, 64'd1);
        @(posedge clk);
        #1;
        req.aw_valid = 1'b0;
        req.w_valid = 1'b0;
        chk("b_valid_latency", {63'd0, resp.b_valid}, 64'd1);
        rsp = resp.b.resp;
        repeat (stall) @(negedge clk);
        chk("b_hold", {61'd0, resp.b_valid, resp.b.resp}, {61'd0, 1'b1, rsp});
        @(negedge clk);
        req.b_ready = 1'b1;
        @(posedge clk);
        #1;
        req.b_ready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input int stall, output logic [63:0] d, output logic [1:0] rsp);
        int n = 0;
        @(negedge clk);
        req.ar.addr = a;
        req.ar.prot = 3'($urandom);
        req.ar_valid = 1'b1;
        req.r_ready = 1'b0;
        #1;
        while (!resp.ar_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("ar_ready", {63'd0, resp.ar_ready}, 64'd1);
        @(posedge clk);
        #1;
        req.ar_valid = 1'b0;
        chk("r_valid_latency", {63'd0, resp.r_valid}, 64'd1);
        d = resp.r.data;
        rsp = resp.r.resp;
        repeat (stall) @(negedge clk);
        chk("r_hold", {resp.r.data ^ d, 1'b0} | {63'd0, ~resp.r_valid} | {62'd0, resp.r.resp ^ rsp}, 64'd0);
        @(negedge clk);
        req.r_ready = 1'b1;
        @(posedge clk);
        #1;
        req.r_ready = 1'b0;
    endtask

    task automatic read_all(input string tag);
        logic [63:0] d;
        logic [1:0]  r;
        for (int i = 0; i < NW; i++) begin
            do_read(BASE + 32'(i * 8), 0, d, r);
            chk($sformatf("%s_data[%0d]", tag, i), d, model[i]);
            chk($sformatf("%s_resp[%0d]", tag, i), {62'd0, r}, 64'd0);
        end
    endtask

    initial begin
        logic [63:0] d;
        logic [1:0]  r;
        logic [31:0] a;
        logic [63:0] wd;
        logic [7:0]  ws;
        int          bad;
        tbl[0]  = '{1'b1, BASE + 32'h008, 64'hDEAD_BEEF_0123_4567, 8'h0F, 2'b00, 64'h0};
        tbl[1]  = '{1'b0, BASE + 32'h00C, 64'h0, 8'h00, 2'b00, 64'h0000_0000_0123_4567};
        tbl[2]  = '{1'b1, BASE + 32'h008, 64'h1111_2222_3333_4444, 8'hF0, 2'b00, 64'h0};
        tbl[3]  = '{1'b0, BASE + 32'h008, 64'h0, 8'h00, 2'b00, 64'h1111_2222_0123_4567};
        tbl[4]  = '{1'b1, BASE + 32'h00B, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 2'b00, 64'h0};
        tbl[5]  = '{1'b0, BASE + 32'h008, 64'h0, 8'h00, 2'b00, 64'h1111_2222_0123_4567};
        tbl[6]  = '{1'b1, BASE + 32'h200, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 2'b10, 64'h0};
        tbl[7]  = '{1'b0, BASE - 32'h008, 64'h0, 8'h00, 2'b10, 64'h0};
        tbl[8]  = '{1'b0, BASE + 32'h1F8, 64'h0, 8'h00, 2'b00, 64'h0};
        tbl[9]  = '{1'b1, BASE + 32'h1FF, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b00, 64'h0};
        tbl[10] = '{1'b0, BASE + 32'h1F8, 64'h0, 8'h00, 2'b00, 64'h0123_4567_89AB_CDEF};
        tbl[11] = '{1'b1, 32'h0000_0000, 64'h5555_5555_5555_5555, 8'hFF, 2'b10, 64'h0};
        tbl[12] = '{1'b0, 32'hFFFF_FFF8, 64'h0, 8'h00, 2'b10, 64'h0};
        req = '0;
        m_clear();

        // Reset
        repeat (5) @(posedge clk);
        #1;
        chk("rst_b_valid", {63'd0, resp.b_valid}, 64'd0);
        chk("rst_r_valid", {63'd0, resp.r_valid}, 64'd0);
        chk("rst_ar_ready", {63'd0, resp.ar_ready}, 64'd1);
        chk("rst_aw_ready_idle", {63'd0, resp.aw_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        read_all("reset");

        // Vector table
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].wr) begin
                do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, r);
                chk($sformatf("tbl%0d_bresp", i), {62'd0, r}, {62'd0, tbl[i].exp_resp});
                void'(m_write(tbl[i].addr, tbl[i].data, tbl[i].strb));
            end else begin
                do_read(tbl[i].addr, 0, d, r);
                chk($sformatf("tbl%0d_rresp", i), {62'd0, r}, {62'd0, tbl[i].exp_resp});
                chk($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_data);
            end
        end
        read_all("after_oor");

        // Lone AW without W must not be accepted
        @(negedge clk);
        req.aw.addr = BASE;
        req.aw_valid = 1'b1;
        #1;
        chk("lone_aw_ready", {62'd0, resp.aw_ready, resp.w_ready}, 64'd0);
        req.aw_valid = 1'b0;

        // Collision + backpressure
        do_write(BASE + 32'd40, 64'h1, 8'hFF, 0, r);
        void'(m_write(BASE + 32'd40, 64'h1, 8'hFF));
        @(negedge clk);
        req.aw.addr = BASE + 32'd40;
        req.w.data = 64'h2;
        req.w.strb = 8'hFF;
        req.aw_valid = 1'b1;
        req.w_valid = 1'b1;
        req.ar.addr = BASE + 32'd40;
        req.ar_valid = 1'b1;
        @(posedge clk);
        #1;
        void'(m_write(BASE + 32'd40, 64'h2, 8'hFF));
        chk("collision_old", resp.r.data, 64'h1);
        chk("collision_valids", {62'd0, resp.b_valid, resp.r_valid}, 64'd3);
        req.aw.addr = BASE + 32'd48;
        req.w.data = 64'h3;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (resp.aw_ready || resp.w_ready || resp.ar_ready || !resp.b_valid || !resp.r_valid ||
                resp.r.data !== 64'h1 || resp.b.resp !== 2'b00) bad++;
        end
        chk("stall_hold_cycles_bad", 64'(bad), 64'd0);
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        #1;
        chk("release_readies", {61'd0, resp.aw_ready, resp.w_ready, resp.ar_ready}, 64'd7);
        @(posedge clk);
        #1;
        void'(m_write(BASE + 32'd48, 64'h3, 8'hFF));
        req.aw_valid = 1'b0;
        req.w_valid = 1'b0;
        req.ar_valid = 1'b0;
        chk("collision_new", resp.r.data, 64'h2);
        chk("second_b_valid", {63'd0, resp.b_valid}, 64'd1);
        @(posedge clk);
        #1;
        chk("drain_valids", {62'd0, resp.b_valid, resp.r_valid}, 64'd0);
        req.b_ready = 1'b0;
        req.r_ready = 1'b0;

        // Back-to-back writes then reads at one per cycle
        @(negedge clk);
        req.b_ready = 1'b1;
        req.aw_valid = 1'b1;
        req.w_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = BASE + 32'(($urandom_range(0, 9) + 60) * 8);
            wd = {$urandom, $urandom};
            ws = 8'($urandom);
            req.aw.addr = a;
            req.w.data = wd;
            req.w.strb = ws;
            @(posedge clk);
            #1;
            chk($sformatf("wstream%0d_b", i), {61'd0, resp.b_valid, resp.b.resp}, {61'd0, 1'b1, m_write(a, wd, ws)});
        end
        req.aw_valid = 1'b0;
        req.w_valid = 1'b0;
        @(posedge clk);
        #1;
        req.b_ready = 1'b0;
        req.r_ready = 1'b1;
        req.ar_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = BASE + 32'(($urandom_range(0, 9) + 58) * 8);
            req.ar.addr = a;
            @(posedge clk);
            #1;
            chk($sformatf("rstream%0d", i), {resp.r.data[61:0], resp.r_valid, resp.r.resp[1]},
                {m_read(a) << 2 | {62'd0, 1'b1, m_resp(a) == 2'b10}});
            chk($sformatf("rstream%0d_top", i), {62'd0, resp.r.data[63:62]}, {62'd0, m_read(a) >> 62});
        end
        req.ar_valid = 1'b0;
        @(posedge clk);
        #1;
        req.r_ready = 1'b0;

        // Randomized traffic with random response stalls
        for (int i = 0; i < 300; i++) begin
            a = BASE + 32'(($urandom_range(0, 71) - 4) * 8 + $urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                wd = {$urandom, $urandom};
                ws = 8'($urandom);
                do_write(a, wd, ws, $urandom_range(0, 3), r);
                chk($sformatf("rand%0d_bresp", i), {62'd0, r}, {62'd0, m_write(a, wd, ws)});
            end else begin
                do_read(a, $urandom_range(0, 3), d, r);
                chk($sformatf("rand%0d_rdata", i), d, m_read(a));
                chk($sformatf("rand%0d_rresp", i), {62'd0, r}, {62'd0, m_resp(a)});
            end
        end
        read_all("after_rand");

        // Asynchronous reset with responses outstanding
        @(negedge clk);
        req.aw.addr = BASE + 32'd16;
        req.w.data = 64'hFEED;
        req.w.strb = 8'hFF;
        req.aw_valid = 1'b1;
        req.w_valid = 1'b1;
        req.ar.addr = BASE + 32'd16;
        req.ar_valid = 1'b1;
        @(posedge clk);
        #1;
        req.aw_valid = 1'b0;
        req.w_valid = 1'b0;
        req.ar_valid = 1'b0;
        chk("pre_rst_valids", {62'd0, resp.b_valid, resp.r_valid}, 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valids", {62'd0, resp.b_valid, resp.r_valid}, 64'd0);
        m_clear();
        @(negedge clk);
        rst_n = 1'b1;
        do_read(BASE + 32'd16, 0, d, r);
        chk("rst_cleared_word", d, 64'h0);
        do_read(BASE + 32'd40, 0, d, r);
        chk("rst_cleared_word5", d, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
